// File: rtl/imem_pf_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
package imem_pf_pkg;

    localparam logic [31:0] WORD_STEP = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } entry_t;

endpackage

// File: rtl/imem_pf_fifo.sv
// Synchronous FIFO of prefetched words; clear wins over push in the same cycle.
module imem_pf_fifo
    import imem_pf_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    input  entry_t                   wdata_i,
    output entry_t                   rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               push_ok, pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // Storage needs no reset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (push_ok && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/imem_prefetch_buffer.sv
// Sequential instruction prefetcher with in-order response FIFO and flush on redirect.
// Optional IMEM_PREFETCH_BYPASS_EN forwards a fresh bus word straight to the core when the FIFO is empty.
module imem_prefetch_buffer
    import imem_pf_pkg::*;
#(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_req,
    input  logic [31:0] core_addr,
    output logic [31:0] core_rdata,
    output logic        core_ready,
    output logic        core_err,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err,
    output logic        prefetch_busy
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    state_e             state_q, state_d;
    logic [31:0]        fetch_addr_q, fetch_addr_d;
    logic [31:0]        head_addr_q, head_addr_d;
    logic [31:0]        bus_addr_q, bus_addr_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]   fifo_count, count_next;
    logic               bus_req_q, bus_req_d;
    logic               stale_q, stale_d;
    logic               busy_q, busy_d;
    logic [31:0]        core_word;
    logic               same_addr, gnt_now, rsp, hit, miss, bypass, push;
    logic               fifo_full, fifo_empty;
    entry_t             fifo_head, push_entry;

    assign push_entry = '{err: bus_err, data: bus_rdata};

    imem_pf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (hit),
        .clear_i (miss),
        .wdata_i (push_entry),
        .rdata_o (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Classify this cycle's core request and bus response.
    always_comb begin
        core_word = core_addr & ~32'd3;
        same_addr = (core_word == head_addr_q);
        gnt_now   = bus_req_q & bus_gnt;
        rsp       = bus_rvalid & (outstanding_q != '0);
        hit       = (state_q != IDLE) & core_req & ~fifo_empty & same_addr;
        miss      = core_req & ~hit & (~same_addr | (state_q == IDLE));
`ifdef IMEM_PREFETCH_BYPASS_EN
        bypass    = (state_q != IDLE) & core_req & same_addr & fifo_empty
                    & (drop_cnt_q == '0) & rsp & ~bus_err;
`else
        bypass    = 1'b0;
`endif
        push      = rsp & (drop_cnt_q == '0) & ~bypass & ~fifo_full;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (miss)                                   state_d = RUN;
        else if (push && bus_err && state_q == RUN) state_d = HALT;
    end

    always_comb begin
        core_ready = hit | bypass;
        core_err   = hit & fifo_head.err;
        core_rdata = '0;
        if (hit)         core_rdata = fifo_head.data;
        else if (bypass) core_rdata = bus_rdata;
    end

    // A request pending at flush time stays on the bus; its response is dropped.
    always_comb begin
        outstanding_d = outstanding_q + CNT_W'(gnt_now) - CNT_W'(rsp);
        count_next    = miss ? '0 : fifo_count + CNT_W'(push) - CNT_W'(hit);
        head_addr_d   = head_addr_q;
        fetch_addr_d  = fetch_addr_q;
        drop_cnt_d    = drop_cnt_q;
        stale_d       = stale_q;
        bus_req_d     = bus_req_q;
        bus_addr_d    = bus_addr_q;

        if (miss)                 head_addr_d = core_word;
        else if (hit || bypass)   head_addr_d = head_addr_q + WORD_STEP;

        if (miss)                    fetch_addr_d = core_word;
        else if (gnt_now && !stale_q) fetch_addr_d = fetch_addr_q + WORD_STEP;

        if (miss) begin
            drop_cnt_d = outstanding_d;
            stale_d    = bus_req_q & ~bus_gnt;
        end else begin
            drop_cnt_d = drop_cnt_q - CNT_W'(rsp && drop_cnt_q != '0)
                                    + CNT_W'(gnt_now && stale_q);
            stale_d    = stale_q & ~gnt_now;
        end

        if (!(bus_req_q && !bus_gnt)) begin
            bus_req_d = (state_d == RUN)
                      && ((SUM_W'(count_next) + SUM_W'(outstanding_d)) < SUM_W'(DEPTH))
                      && (outstanding_d < CNT_W'(MAX_OUTSTANDING));
            if (bus_req_d) bus_addr_d = fetch_addr_d;
        end

        busy_d = (outstanding_d != '0) | bus_req_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_addr_q  <= '0;
            head_addr_q   <= '0;
            bus_addr_q    <= '0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            bus_req_q     <= 1'b0;
            stale_q       <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            fetch_addr_q  <= fetch_addr_d;
            head_addr_q   <= head_addr_d;
            bus_addr_q    <= bus_addr_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            bus_req_q     <= bus_req_d;
            stale_q       <= stale_d;
            busy_q        <= busy_d;
        end
    end

    assign bus_req       = bus_req_q;
    assign bus_addr      = bus_addr_q;
    assign prefetch_busy = busy_q;

endmodule

// File: tb/tb_imem_prefetch_buffer.sv
// Scoreboard bench: every delivered word must equal memory at the fetched address.
module tb_imem_prefetch_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned MAXO  = 2;
`ifdef IMEM_PREFETCH_BYPASS_EN
    localparam int FIRST_LAT = 2;
`else
    localparam int FIRST_LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req;
    logic [31:0] core_addr;
    logic [31:0] core_rdata;
    logic        core_ready;
    logic        core_err;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_err;
    logic        prefetch_busy;

    always #5 clk = ~clk;

    imem_prefetch_buffer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .core_req      (core_req),
        .core_addr     (core_addr),
        .core_rdata    (core_rdata),
        .core_ready    (core_ready),
        .core_err      (core_err),
        .bus_req       (bus_req),
        .bus_addr      (bus_addr),
        .bus_gnt       (bus_gnt),
        .bus_rvalid    (bus_rvalid),
        .bus_rdata     (bus_rdata),
        .bus_err       (bus_err),
        .prefetch_busy (prefetch_busy)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Memory contents seen by the bus and expected by the core.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
    endfunction

    typedef struct { logic [31:0] addr; int ready; } pend_t;
    typedef struct { logic [31:0] data; logic err; } exp_t;

    pend_t       pend_q[$];
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] err_addr  = 32'h1;
    int          cyc       = 0;
    int          gnt_prob  = 100;
    bit          gnt_en    = 1'b1;
    int          lat_min   = 1;
    int          lat_max   = 1;
    int          grant_cnt = 0;
    bit          prev_pend = 1'b0;
    logic [31:0] prev_addr = '0;

    // Bus slave: record handshakes and retire responses mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend_q.delete();
        end else begin
            if (bus_rvalid && pend_q.size() > 0) void'(pend_q.pop_front());
            if (bus_req && bus_gnt) begin
                pend_q.push_back('{addr: bus_addr, ready: cyc + int'($urandom_range(lat_max, lat_min))});
                grant_cnt++;
            end
        end
    end

    always @(posedge clk) begin
        cyc++;
        #2;
        bus_gnt = gnt_en && (int'($urandom_range(99, 0)) < gnt_prob);
        if (rst_n && pend_q.size() > 0 && pend_q[0].ready <= cyc) begin
            bus_rvalid = 1'b1;
            bus_rdata  = mem_word(pend_q[0].addr);
            bus_err    = (pend_q[0].addr == err_addr);
        end else begin
            bus_rvalid = 1'b0;
            bus_rdata  = $urandom;
            bus_err    = 1'($urandom_range(1, 0));
        end
    end

    // Monitor: scoreboard pop on core_ready plus bus hold checks.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_pend = 1'b0;
        end else begin
            if (core_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_ready: got core_ready=1 required 0 (no fetch pending)");
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("core_rdata", core_rdata, mon_e.data);
                    chk("core_err", 32'(core_err), 32'(mon_e.err));
                end
            end else begin
                chk("rdata_idle_zero", core_rdata, 32'h0);
            end
            if (prev_pend) begin
                chk("bus_req_hold", 32'(bus_req), 32'h1);
                chk("bus_addr_hold", bus_addr, prev_addr);
            end
            if (bus_req) chk("bus_addr_align", bus_addr & 32'h3, 32'h0);
            prev_pend = bus_req && !bus_gnt;
            prev_addr = bus_addr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        core_req = 1'b0;
        repeat (n) tick();
    endtask

    // Issue one fetch, hold it until served; returns cycles waited.
    task automatic fetch(input logic [31:0] a, output int lat);
        bit done;
        exp_q.push_back('{data: mem_word(a), err: (a == err_addr)});
        core_req  = 1'b1;
        core_addr = a | 32'($urandom_range(3, 0));
        lat  = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (core_ready) begin
                done = 1'b1;
            end else if (lat >= 200) begin
                n_cmp++;
                n_fail++;
                $display("FAIL fetch_timeout: got no core_ready for 0x%08h required within 200 cycles", a);
                exp_q.delete();
                done = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                lat++;
            end
        end
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish required end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          g0;
        logic [31:0] a;
        logic [31:0] nxt;
        bit          last_err;

        rst_n      = 1'b0;
        core_req   = 1'b0;
        core_addr  = '0;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = '0;
        bus_err    = 1'b0;
        repeat (3) tick();
        chk("rst_bus_req", 32'(bus_req), 32'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_core_ready", 32'(core_ready), 32'h0);
        chk("rst_core_err", 32'(core_err), 32'h0);
        chk("rst_core_rdata", core_rdata, 32'h0);
        chk("rst_busy", 32'(prefetch_busy), 32'h0);
        rst_n = 1'b1;
        tick();

        // First fetch latency, then one word per cycle.
        fetch(32'h0, lat);
        chk("first_latency", 32'(lat), 32'(FIRST_LAT));
        for (int i = 1; i < 8; i++) begin
            fetch(32'(i * 4), lat);
            chk("stream_latency", 32'(lat), 32'h0);
        end

        // Redirect with two responses in flight.
        lat_min = 2;
        lat_max = 2;
        for (int i = 0; i < 8; i++) fetch(32'h300 + 32'(i * 4), lat);
        for (int i = 0; i < 4; i++) fetch(32'h100 + 32'(i * 4), lat);

        // Redirect while the bus request is held off.
        lat_min = 1;
        lat_max = 1;
        for (int i = 0; i < 3; i++) fetch(32'h500 + 32'(i * 4), lat);
        gnt_en = 1'b0;
        fetch(32'h50C, lat);
        idle(1);
        chk("req_pending_gnt_low", 32'(bus_req), 32'h1);
        a = bus_addr;
        fork
            fetch(32'h100, lat);
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("gnt_low_addr", bus_addr, a);
                end
                @(posedge clk);
                #1;
                gnt_en = 1'b1;
            end
        join
        fetch(32'h104, lat);

        // Core stall fills exactly DEPTH entries.
        idle(20);
        g0 = grant_cnt;
        fetch(32'h200, lat);
        fetch(32'h204, lat);
        idle(20);
        chk("stall_bus_req", 32'(bus_req), 32'h0);
        chk("stall_busy", 32'(prefetch_busy), 32'h0);
        chk("stall_buffered", 32'(grant_cnt - g0 - 2), 32'(DEPTH));
        for (int i = 2; i < 6; i++) begin
            fetch(32'h200 + 32'(i * 4), lat);
            chk("stall_hit_latency", 32'(lat), 32'h0);
        end

        // Bus error halts prefetching until a redirect.
        err_addr = 32'h8;
        fetch(32'h0, lat);
        fetch(32'h4, lat);
        fetch(32'h8, lat);
        idle(10);
        g0 = grant_cnt;
        idle(10);
        chk("halt_bus_req", 32'(bus_req), 32'h0);
        chk("halt_busy", 32'(prefetch_busy), 32'h0);
        chk("halt_no_grants", 32'(grant_cnt), 32'(g0));
        fetch(32'h40, lat);
        chk("resume_latency", 32'(lat), 32'(FIRST_LAT));
        fetch(32'h44, lat);
        err_addr = 32'h1;

        // Address wrap.
        idle(2);
        fetch(32'hFFFF_FFF8, lat);
        fetch(32'hFFFF_FFFC, lat);
        fetch(32'h0000_0000, lat);
        fetch(32'h0000_0004, lat);

        // Randomized traffic.
        err_addr = 32'h88;
        a        = 32'h80;
        last_err = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) begin
                gnt_prob = int'($urandom_range(100, 40));
                lat_max  = int'($urandom_range(4, 1));
            end
            nxt = a + 32'h4;
            if (last_err || $urandom_range(99, 0) < 20) begin
                if ($urandom_range(3, 0) == 0) nxt = 32'hFFFF_FF00 + 32'($urandom_range(63, 0) * 4);
                else                           nxt = 32'($urandom_range(63, 0) * 4);
                if (last_err && nxt == a + 32'h4) nxt = nxt + 32'h8;
            end
            a = nxt;
            if ($urandom_range(9, 0) == 0) idle(int'($urandom_range(3, 1)));
            fetch(a, lat);
            last_err = (a == err_addr);
        end
        err_addr = 32'h1;
        gnt_prob = 100;
        lat_max  = 2;
        lat_min  = 2;

        // Reset in the middle of traffic.
        fetch(32'h600, lat);
        fetch(32'h604, lat);
        rst_n    = 1'b0;
        core_req = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_bus_req", 32'(bus_req), 32'h0);
        chk("midrst_bus_addr", bus_addr, 32'h0);
        chk("midrst_busy", 32'(prefetch_busy), 32'h0);
        chk("midrst_core_ready", 32'(core_ready), 32'h0);
        repeat (3) tick();
        rst_n   = 1'b1;
        lat_min = 1;
        lat_max = 1;
        tick();
        fetch(32'h0, lat);
        chk("post_reset_latency", 32'(lat), 32'(FIRST_LAT));
        fetch(32'h4, lat);
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
